// File: rtl/pc_multi_context_pkg.sv
// Shared types and helpers for the multi-context program counter.
//   pc_state_t : RUN / SWITCH / HALT controller states
//   ctx_w()    : context-index width, never narrower than 1 bit
//   rr_next()  : index of the next set mask bit after cur (wrapping), -1 if none
// The time-slice feature is selected with the PC_QUANTUM_EN macro in the top.
package pc_ctx_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SWITCH = 2'd1,
        HALT   = 2'd2
    } pc_state_t;

    localparam int RR_MAX = 32;

    function automatic int ctx_w(input int n);
        int w;
        w = (n <= 2) ? 1 : $clog2(n);
        return w;
    endfunction

    // Searches cur+1 .. cur+n-1 (mod n); cur itself is never a candidate.
    function automatic int rr_next(input logic [RR_MAX-1:0] mask, input int cur, input int n);
        int res;
        int idx;
        res = -1;
        for (int k = 1; k < RR_MAX; k++) begin
            if (k < n) begin
                idx = (cur + k) % n;
                if (res < 0 && mask[idx[4:0]]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_multi_context_if.sv
// Pipeline / OS-unit bundle for pc_multi_context.
//   master : next-PC logic and kernel unit (drive stall/isHalt/pcNext/ctx*)
//   slave  : the PC unit (drives pcAtual/pcValid/ctxAtual/halted/haltMask/preempt)
interface pc_multi_context_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_CTX = 4
);
    import pc_ctx_pkg::*;
    localparam int CTX_W = ctx_w(NUM_CTX);

    logic               stall;
    logic               isHalt;
    logic [WIDTH-1:0]   pcNext;
    logic               ctxSwitch;
    logic [CTX_W-1:0]   ctxTarget;
    logic               ctxLoad;
    logic [CTX_W-1:0]   ctxLoadIdx;
    logic [WIDTH-1:0]   ctxLoadVal;
    logic [WIDTH-1:0]   pcAtual;
    logic               pcValid;
    logic [CTX_W-1:0]   ctxAtual;
    logic               halted;
    logic [NUM_CTX-1:0] haltMask;
    logic               preempt;

    modport master (
        output stall, isHalt, pcNext, ctxSwitch, ctxTarget, ctxLoad, ctxLoadIdx, ctxLoadVal,
        input  pcAtual, pcValid, ctxAtual, halted, haltMask, preempt
    );

    modport slave (
        input  stall, isHalt, pcNext, ctxSwitch, ctxTarget, ctxLoad, ctxLoadIdx, ctxLoadVal,
        output pcAtual, pcValid, ctxAtual, halted, haltMask, preempt
    );

endinterface

// File: rtl/pc_multi_context_rr_picker.sv
// Combinational round-robin search for the next runnable context after i_cur.
//   i_mask  : runnable contexts (1 = may be scheduled)
//   i_cur   : current context (excluded from the search)
//   o_found : a different runnable context exists
//   o_idx   : that context (don't-care when o_found=0)
module pc_rr_picker
    import pc_ctx_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = ctx_w(NUM_CTX)
) (
    input  logic [NUM_CTX-1:0] i_mask,
    input  logic [CTX_W-1:0]   i_cur,
    output logic               o_found,
    output logic [CTX_W-1:0]   o_idx
);

    logic [RR_MAX-1:0] w_mask;
    int                w_next;

    always_comb begin
        w_mask                = '0;
        w_mask[NUM_CTX-1:0]   = i_mask;
        w_next                = rr_next(w_mask, int'(i_cur), NUM_CTX);
    end

    assign o_found = (w_next >= 0);
    assign o_idx   = CTX_W'(w_next);

endmodule

// File: rtl/pc_multi_context.sv
// Multi-context program counter: one saved PC and halt flag per hardware context,
// OS-driven context switch with a one-cycle bubble, stall, halt and context restore.
// Optional time-slice preemption is built when PC_QUANTUM_EN is defined.
//   clock, resetCPU  : rising-edge clock, synchronous active-high reset
//   bus (slave)      : stall/isHalt/pcNext/ctxSwitch/ctxTarget/ctxLoad* in,
//                      pcAtual/pcValid/ctxAtual/halted/haltMask/preempt out
//
// state  | meaning
// RUN    | current context fetching, pcValid=1
// SWITCH | one-cycle bubble after a context change
// HALT   | current context halted, waits for switch or ctxLoad
module pc_multi_context
    import pc_ctx_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NUM_CTX   = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               QUANTUM   = 64
) (
    input  logic             clock,
    input  logic             resetCPU,
    pc_multi_context_if.slave bus
);

    localparam int CTX_W = ctx_w(NUM_CTX);

    pc_state_t          r_state, w_state_n;
    logic [WIDTH-1:0]   r_pc, w_pc_n;
    logic [CTX_W-1:0]   r_cur, w_cur_n;
    logic [NUM_CTX-1:0] r_halt, w_halt_n;
    logic [WIDTH-1:0]   r_ctx_pc   [NUM_CTX];
    logic [WIDTH-1:0]   w_ctx_pc_n [NUM_CTX];

    logic               w_ext_sw, w_sw, w_load, w_preempt;
    logic [CTX_W-1:0]   w_tgt, w_pre_tgt;

    // Out-of-range targets and self-switches never start a bubble.
    assign w_ext_sw = bus.ctxSwitch && (32'(bus.ctxTarget) < 32'(NUM_CTX))
                      && (bus.ctxTarget != r_cur) && (r_state != SWITCH);
    assign w_sw     = w_ext_sw || w_preempt;
    assign w_tgt    = w_ext_sw ? bus.ctxTarget : w_pre_tgt;
    assign w_load   = bus.ctxLoad && (32'(bus.ctxLoadIdx) < 32'(NUM_CTX));

`ifdef PC_QUANTUM_EN
    localparam int CNT_W = $clog2(QUANTUM);
    logic [CNT_W-1:0] r_cnt;
    logic             w_rr_found;
    logic [CTX_W-1:0] w_rr_idx;

    pc_rr_picker #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) u_rr (
        .i_mask  (~r_halt),
        .i_cur   (r_cur),
        .o_found (w_rr_found),
        .o_idx   (w_rr_idx)
    );

    // No runnable peer means no pulse; the counter simply wraps.
    assign w_preempt = (r_state == RUN) && (r_cnt == CNT_W'(QUANTUM - 1))
                       && !bus.ctxSwitch && w_rr_found;
    assign w_pre_tgt = w_rr_idx;

    always_ff @(posedge clock) begin
        if (resetCPU || w_sw) begin
            r_cnt <= '0;
        end else if (r_state == RUN && !bus.stall) begin
            r_cnt <= (r_cnt == CNT_W'(QUANTUM - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_preempt = 1'b0;
    assign w_pre_tgt = '0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_cur_n   = r_cur;
        w_halt_n  = r_halt;
        for (int i = 0; i < NUM_CTX; i++) begin
            w_ctx_pc_n[i] = r_ctx_pc[i];
        end

        case (r_state)
            RUN: begin
                if (w_sw) begin
                    w_ctx_pc_n[r_cur] = bus.stall ? r_pc : bus.pcNext;
                    w_cur_n           = w_tgt;
                    w_pc_n            = r_ctx_pc[w_tgt];
                end else if (!bus.stall) begin
                    w_pc_n            = bus.pcNext;
                    w_ctx_pc_n[r_cur] = bus.pcNext;
                end
                if (bus.isHalt) begin
                    w_halt_n[r_cur] = 1'b1;
                end
            end
            HALT: begin
                // Saved PC already equals pcAtual while halted, nothing to save.
                if (w_sw) begin
                    w_cur_n = w_tgt;
                    w_pc_n  = r_ctx_pc[w_tgt];
                end
            end
            default: ;
        endcase

        // Restore wins over advance/halt; it lands in pcAtual only for the
        // context that will be current after this edge.
        if (w_load) begin
            w_ctx_pc_n[bus.ctxLoadIdx] = bus.ctxLoadVal;
            w_halt_n[bus.ctxLoadIdx]   = 1'b0;
            if (w_sw ? (bus.ctxLoadIdx == w_tgt) : (bus.ctxLoadIdx == r_cur)) begin
                w_pc_n = bus.ctxLoadVal;
            end
        end

        if (w_sw) begin
            w_state_n = SWITCH;
        end else begin
            w_state_n = w_halt_n[w_cur_n] ? HALT : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (resetCPU) begin
            r_state <= RUN;
            r_pc    <= RESET_VEC;
            r_cur   <= '0;
            r_halt  <= '0;
            for (int i = 0; i < NUM_CTX; i++) begin
                r_ctx_pc[i] <= RESET_VEC;
            end
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_cur    <= w_cur_n;
            r_halt   <= w_halt_n;
            r_ctx_pc <= w_ctx_pc_n;
        end
    end

    assign bus.pcAtual  = r_pc;
    assign bus.pcValid  = (r_state == RUN);
    assign bus.ctxAtual = r_cur;
    assign bus.halted   = r_halt[r_cur];
    assign bus.haltMask = r_halt;
    assign bus.preempt  = w_preempt;

endmodule

// File: tb/tb_pc_multi_context.sv
// Directed bench for pc_multi_context. Expected outputs are queued with each
// stimulus step and compared after the following rising edge.
module tb_pc_multi_context;
    import pc_ctx_pkg::*;

    localparam int W = 32;
    localparam int N = 4;
`ifdef PC_QUANTUM_EN
    localparam int Q = 4;
`else
    localparam int Q = 64;
`endif

    logic clock = 1'b0;
    logic resetCPU;
    always #5 clock = ~clock;

    pc_multi_context_if #(.WIDTH(W), .NUM_CTX(N)) bus ();

    pc_multi_context #(
        .WIDTH(W), .NUM_CTX(N), .RESET_VEC(32'h0), .QUANTUM(Q)
    ) dut (
        .clock    (clock),
        .resetCPU (resetCPU),
        .bus      (bus.slave)
    );

    typedef struct {
        string          tag;
        logic [W-1:0]   pc;
        logic           valid;
        logic [1:0]     ctx;
        logic           halted;
        logic [N-1:0]   mask;
        logic           pre;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check1({e.tag, ".pcAtual"},  bus.pcAtual,         e.pc);
            check1({e.tag, ".pcValid"},  32'(bus.pcValid),    32'(e.valid));
            check1({e.tag, ".ctxAtual"}, 32'(bus.ctxAtual),   32'(e.ctx));
            check1({e.tag, ".halted"},   32'(bus.halted),     32'(e.halted));
            check1({e.tag, ".haltMask"}, 32'(bus.haltMask),   32'(e.mask));
            check1({e.tag, ".preempt"},  32'(bus.preempt),    32'(e.pre));
        end
    endtask

    task automatic step(input string tag, input logic [W-1:0] pc, input logic v,
                        input logic [1:0] c, input logic h, input logic [N-1:0] m,
                        input logic p);
        exp_t e;
        e.tag = tag; e.pc = pc; e.valid = v; e.ctx = c; e.halted = h; e.mask = m; e.pre = p;
        sb.push_back(e);
        tick();
    endtask

    task automatic idle_in();
        bus.stall      = 1'b0;
        bus.isHalt     = 1'b0;
        bus.ctxSwitch  = 1'b0;
        bus.ctxTarget  = '0;
        bus.ctxLoad    = 1'b0;
        bus.ctxLoadIdx = '0;
        bus.ctxLoadVal = '0;
    endtask

    task automatic do_switch(input logic [1:0] t, input logic [W-1:0] nxt);
        bus.ctxSwitch = 1'b1;
        bus.ctxTarget = t;
        bus.pcNext    = nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        bus.pcNext = '0;
        resetCPU   = 1'b1;
        step("reset", 32'h0, 1, 0, 0, 4'b0000, 0);
        resetCPU = 1'b0;

`ifndef PC_QUANTUM_EN
        for (int i = 1; i <= 4; i++) begin
            bus.pcNext = 32'(i * 4);
            step("advance", 32'(i * 4), 1, 0, 0, 4'b0000, 0);
        end
        bus.stall = 1'b1; bus.pcNext = 32'h55;
        step("stall_hold", 32'h10, 1, 0, 0, 4'b0000, 0);
        bus.stall = 1'b0;
        do_switch(2'd0, 32'h1C);
        step("self_switch", 32'h1C, 1, 0, 0, 4'b0000, 0);
        idle_in();

        bus.isHalt = 1'b1; bus.pcNext = 32'h20;
        step("halt_edge", 32'h20, 0, 0, 1, 4'b0001, 0);
        bus.isHalt = 1'b0; bus.pcNext = 32'h99;
        repeat (3) step("halt_frozen", 32'h20, 0, 0, 1, 4'b0001, 0);
        bus.ctxLoad = 1'b1; bus.ctxLoadIdx = 2'd0; bus.ctxLoadVal = 32'h2C;
        step("load_cur_wake", 32'h2C, 1, 0, 0, 4'b0000, 0);
        idle_in();

        bus.ctxLoad = 1'b1; bus.ctxLoadIdx = 2'd1; bus.ctxLoadVal = 32'h100;
        do_switch(2'd1, 32'h30);
        step("load_and_switch", 32'h100, 0, 1, 0, 4'b0000, 0);
        idle_in();
        bus.isHalt = 1'b1; bus.stall = 1'b1; bus.pcNext = 32'h77;
        step("bubble_ignores_halt", 32'h100, 1, 1, 0, 4'b0000, 0);
        idle_in();
        bus.pcNext = 32'h104;
        step("ctx1_adv", 32'h104, 1, 1, 0, 4'b0000, 0);
        do_switch(2'd0, 32'h108);
        step("switch_back", 32'h30, 0, 0, 0, 4'b0000, 0);
        idle_in();
        step("switch_back_run", 32'h30, 1, 0, 0, 4'b0000, 0);
        bus.pcNext = 32'h40;
        step("ctx0_adv", 32'h40, 1, 0, 0, 4'b0000, 0);

        bus.stall = 1'b1;
        do_switch(2'd1, 32'h77);
        step("switch_stalled", 32'h108, 0, 1, 0, 4'b0000, 0);
        idle_in();
        step("ctx1_run", 32'h108, 1, 1, 0, 4'b0000, 0);
        do_switch(2'd0, 32'h10C);
        step("restore_ctx0", 32'h40, 0, 0, 0, 4'b0000, 0);
        do_switch(2'd2, 32'h10C);
        step("switch_dropped_in_bubble", 32'h40, 1, 0, 0, 4'b0000, 0);
        idle_in();

        do_switch(2'd2, 32'h4C);
        step("sw_ctx2", 32'h0, 0, 2, 0, 4'b0000, 0);
        idle_in();
        step("ctx2_run", 32'h0, 1, 2, 0, 4'b0000, 0);
        bus.isHalt = 1'b1; bus.pcNext = 32'h4;
        step("halt_ctx2", 32'h4, 0, 2, 1, 4'b0100, 0);
        idle_in();
        do_switch(2'd0, 32'h99);
        step("sw_from_halt", 32'h4C, 0, 0, 0, 4'b0100, 0);
        idle_in();
        step("ctx0_after_halt", 32'h4C, 1, 0, 0, 4'b0100, 0);
        do_switch(2'd2, 32'h50);
        step("sw_to_halted", 32'h4, 0, 2, 1, 4'b0100, 0);
        idle_in();
        step("halted_after_bubble", 32'h4, 0, 2, 1, 4'b0100, 0);
        step("halted_stays", 32'h4, 0, 2, 1, 4'b0100, 0);
        bus.ctxLoad = 1'b1; bus.ctxLoadIdx = 2'd2; bus.ctxLoadVal = 32'h200;
        step("load_wakes_ctx2", 32'h200, 1, 2, 0, 4'b0000, 0);
        idle_in();
        bus.pcNext = 32'h204;
        step("ctx2_adv", 32'h204, 1, 2, 0, 4'b0000, 0);
        bus.ctxLoad = 1'b1; bus.ctxLoadIdx = 2'd1; bus.ctxLoadVal = 32'h300; bus.pcNext = 32'h208;
        step("load_other_ctx", 32'h208, 1, 2, 0, 4'b0000, 0);
        idle_in();
        do_switch(2'd1, 32'h20C);
        step("sw_to_loaded", 32'h300, 0, 1, 0, 4'b0000, 0);
        idle_in();
        step("ctx1_loaded_run", 32'h300, 1, 1, 0, 4'b0000, 0);
        do_switch(2'd0, 32'h304);
        step("final_switch", 32'h50, 0, 0, 0, 4'b0000, 0);
`else
        do_switch(2'd3, 32'h10);
        step("q_sw3", 32'h0, 0, 3, 0, 4'b0000, 0);
        idle_in();
        step("q_run3", 32'h0, 1, 3, 0, 4'b0000, 0);
        bus.isHalt = 1'b1; bus.pcNext = 32'h4;
        step("q_halt3", 32'h4, 0, 3, 1, 4'b1000, 0);
        idle_in();
        do_switch(2'd2, 32'h99);
        step("q_sw2", 32'h0, 0, 2, 0, 4'b1000, 0);
        idle_in();
        step("q_run2", 32'h0, 1, 2, 0, 4'b1000, 0);
        bus.isHalt = 1'b1; bus.pcNext = 32'h8;
        step("q_halt2", 32'h8, 0, 2, 1, 4'b1100, 0);
        idle_in();
        do_switch(2'd0, 32'h99);
        step("q_sw0", 32'h10, 0, 0, 0, 4'b1100, 0);
        idle_in();
        step("q_run0", 32'h10, 1, 0, 0, 4'b1100, 0);
        bus.pcNext = 32'h14; step("q_c1", 32'h14, 1, 0, 0, 4'b1100, 0);
        bus.pcNext = 32'h18; step("q_c2", 32'h18, 1, 0, 0, 4'b1100, 0);
        bus.pcNext = 32'h1C; step("q_pulse0", 32'h1C, 1, 0, 0, 4'b1100, 1);
        bus.pcNext = 32'h20; step("q_preempt_to1", 32'h0, 0, 1, 0, 4'b1100, 0);
        step("q_run1", 32'h0, 1, 1, 0, 4'b1100, 0);
        bus.pcNext = 32'h4; step("q1_c1", 32'h4, 1, 1, 0, 4'b1100, 0);
        bus.pcNext = 32'h8; step("q1_c2", 32'h8, 1, 1, 0, 4'b1100, 0);
        bus.pcNext = 32'hC; step("q_pulse1", 32'hC, 1, 1, 0, 4'b1100, 1);
        bus.pcNext = 32'h10; step("q_preempt_skip_halted", 32'h20, 0, 0, 0, 4'b1100, 0);
        step("q_back0", 32'h20, 1, 0, 0, 4'b1100, 0);
        bus.stall = 1'b1;
        repeat (2) step("q_stall_no_count", 32'h20, 1, 0, 0, 4'b1100, 0);
        bus.stall = 1'b0;
        bus.pcNext = 32'h24; step("q_s1", 32'h24, 1, 0, 0, 4'b1100, 0);
        bus.pcNext = 32'h28; step("q_s2", 32'h28, 1, 0, 0, 4'b1100, 0);
        bus.pcNext = 32'h2C; step("q_pulse_after_stall", 32'h2C, 1, 0, 0, 4'b1100, 1);
        do_switch(2'd1, 32'h30);
        #1;
        check1("q_ext_switch_wins.preempt", 32'(bus.preempt), 32'h0);
        step("q_ext_switch", 32'h10, 0, 1, 0, 4'b1100, 0);
        idle_in();
        step("q_ext_run", 32'h10, 1, 1, 0, 4'b1100, 0);
        do_switch(2'd0, 32'h14);
        step("final_switch", 32'h30, 0, 0, 0, 4'b1100, 0);
`endif

        idle_in();
        resetCPU = 1'b1;
        step("reset_mid_switch", 32'h0, 1, 0, 0, 4'b0000, 0);
        resetCPU = 1'b0;
        do_switch(2'd1, 32'h4);
        step("reset_cleared_saved_pc", 32'h0, 0, 1, 0, 4'b0000, 0);
        idle_in();
        step("post_reset_run", 32'h0, 1, 1, 0, 4'b0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
